// File: rtl/mdu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mdu_seq                                                         |
// | Purpose  : Iterative 32-bit multiply/divide unit (mult/multu/div/divu)     |
// |            with its sequencer and the architectural HI/LO registers.       |
// | Options  : MDU_DIV_EN - include the restoring divider; when undefined,     |
// |            div/divu complete at once with unsupported=1.                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mdu_seq (
    input  logic        ph1,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        divzero,
    output logic        unsupported
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [5:0] c_LAST_ITER = 6'd31;

    state_t      r_state;
    state_t      w_next;
    logic        r_sgn;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_m;
    logic [63:0] r_p;
    logic [5:0]  r_cnt;
    logic        r_sa;
    logic        r_sb;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_idle;
    logic        w_accept;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_step;
    logic [63:0] w_mul_res;
    logic [63:0] w_run_step;
    logic [31:0] w_prep_m;
    logic [31:0] w_prep_p;
    logic [31:0] w_fix_hi;
    logic [31:0] w_fix_lo;

`ifdef MDU_DIV_EN
    logic        r_div;
    logic        r_divzero;
    logic        w_bzero;
    logic [32:0] w_rs;
    logic [32:0] w_diff;
    logic [63:0] w_div_step;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
`else
    logic        r_unsup;
`endif

    function automatic logic [31:0] f_abs(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? (32'd0 - x) : x;
    endfunction

    assign w_idle   = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept = start && w_idle;
    assign w_abs_a  = f_abs(r_a, r_sgn);
    assign w_abs_b  = f_abs(r_b, r_sgn);

    // Shift-add: the 33-bit sum carries into the top of the shifted product.
    assign w_mul_sum  = {1'b0, r_p[63:32]} + (r_p[0] ? {1'b0, r_m} : 33'd0);
    assign w_mul_step = {w_mul_sum, r_p[31:1]};
    assign w_mul_res  = (r_sa ^ r_sb) ? (64'd0 - r_p) : r_p;

`ifdef MDU_DIV_EN
    // Restoring divide: {R,Q} in r_p, divisor magnitude in r_m.
    // The partial remainder stays below the divisor, so a 33-bit trial suffices.
    assign w_bzero    = (r_b == 32'd0);
    assign w_rs       = {r_p[63:32], r_p[31]};
    assign w_diff     = w_rs - {1'b0, r_m};
    assign w_div_step = w_diff[32] ? {w_rs[31:0], r_p[30:0], 1'b0}
                                   : {w_diff[31:0], r_p[30:0], 1'b1};
    assign w_quo      = (r_sa ^ r_sb) ? (32'd0 - r_p[31:0]) : r_p[31:0];
    assign w_rem      = r_sa ? (32'd0 - r_p[63:32]) : r_p[63:32];

    assign w_run_step = r_div ? w_div_step : w_mul_step;
    assign w_prep_m   = r_div ? w_abs_b : w_abs_a;
    assign w_prep_p   = r_div ? w_abs_a : w_abs_b;
    assign w_fix_hi   = r_div ? w_rem : w_mul_res[63:32];
    assign w_fix_lo   = r_div ? w_quo : w_mul_res[31:0];
`else
    assign w_run_step = w_mul_step;
    assign w_prep_m   = w_abs_a;
    assign w_prep_p   = w_abs_b;
    assign w_fix_hi   = w_mul_res[63:32];
    assign w_fix_lo   = w_mul_res[31:0];
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_next = S_IDLE;
                if (w_accept) begin
`ifdef MDU_DIV_EN
                    w_next = S_PREP;
`else
                    w_next = op[1] ? S_DONE : S_PREP;
`endif
                end
            end
            S_PREP: begin
`ifdef MDU_DIV_EN
                w_next = (r_div && w_bzero) ? S_DONE : S_RUN;
`else
                w_next = S_RUN;
`endif
            end
            S_RUN: begin
                if (r_cnt == c_LAST_ITER) begin
                    w_next = S_FIX;
                end
            end
            S_FIX:   w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ph1) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_done    <= 1'b0;
`ifdef MDU_DIV_EN
            r_divzero <= 1'b0;
`else
            r_unsup   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_done  <= (w_next == S_DONE);
`ifdef MDU_DIV_EN
            r_divzero <= (r_state == S_PREP) && r_div && w_bzero;
`else
            r_unsup   <= w_accept && op[1];
`endif
            // An accepted start takes priority over mthi/mtlo in the same cycle.
            if (w_accept) begin
                r_sgn <= ~op[0];
                r_a   <= a;
                r_b   <= b;
`ifdef MDU_DIV_EN
                r_div <= op[1];
`endif
            end else if (w_idle) begin
                if (wr_hi) r_hi <= wdata;
                if (wr_lo) r_lo <= wdata;
            end

            case (r_state)
                S_PREP: begin
                    r_sa  <= r_sgn & r_a[31];
                    r_sb  <= r_sgn & r_b[31];
                    r_cnt <= 6'd0;
                    r_m   <= w_prep_m;
                    r_p   <= {32'd0, w_prep_p};
`ifdef MDU_DIV_EN
                    if (r_div && w_bzero) begin
                        r_hi <= r_a;
                        r_lo <= 32'hFFFF_FFFF;
                    end
`endif
                end
                S_RUN: begin
                    r_p   <= w_run_step;
                    r_cnt <= r_cnt + 6'd1;
                end
                S_FIX: begin
                    r_hi <= w_fix_hi;
                    r_lo <= w_fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == S_PREP) || (r_state == S_RUN) || (r_state == S_FIX);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
`ifdef MDU_DIV_EN
    assign divzero     = r_divzero;
    assign unsupported = 1'b0;
`else
    assign divzero     = 1'b0;
    assign unsupported = r_unsup;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mdu_seq                                                      |
// | Purpose  : Scoreboard bench for mdu_seq using hand-computed vectors.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mdu_seq;

    logic        ph1   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] a     = 32'd0;
    logic [31:0] b     = 32'd0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        divzero;
    logic        unsupported;

    mdu_seq dut (
        .ph1         (ph1),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .wr_hi       (wr_hi),
        .wr_lo       (wr_lo),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .divzero     (divzero),
        .unsupported (unsupported)
    );

    always #5 ph1 = ~ph1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        logic        un;
        int          lat;
        int          scyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc    = 0;
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;

    always @(posedge ph1) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge ph1) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL stray_done: got done at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
                chk("divzero", {31'd0, divzero}, {31'd0, e.dz});
                chk("unsupported", {31'd0, unsupported}, {31'd0, e.un});
                chk("latency", 32'(cyc - e.scyc), 32'(e.lat));
            end
        end
    end

    // Called at a negedge; leaves start asserted across exactly one edge.
    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz, input logic eun, input int elat);
        exp_t e;
        e.hi   = ehi;
        e.lo   = elo;
        e.dz   = edz;
        e.un   = eun;
        e.lat  = elat;
        e.scyc = cyc;
        sb.push_back(e);
        m_hi  = ehi;
        m_lo  = elo;
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge ph1);
        start = 1'b0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
    endtask

    // Returns in the done cycle so the next launch is back-to-back.
    task automatic wait_done(input int ebusy, input string name);
        int nb;
        bit seen;
        nb   = 0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nb++;
            @(negedge ph1);
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_timeout: got no done, expected done within 60 cycles", name);
        end
        chk({name, "_busy_cycles"}, 32'(nb), 32'(ebusy));
    endtask

    task automatic div_case(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] qhi, input logic [31:0] qlo,
                            input logic dz, input string name);
        logic        eun;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          lat;
        int          nb;
`ifdef MDU_DIV_EN
        eun = 1'b0;
`else
        eun = 1'b1;
`endif
        ehi = eun ? m_hi : qhi;
        elo = eun ? m_lo : qlo;
        lat = eun ? 1 : (dz ? 2 : 35);
        nb  = eun ? 0 : (dz ? 1 : 34);
        launch(o, x, y, ehi, elo, dz & ~eun, eun, lat);
        wait_done(nb, name);
    endtask

    initial begin
        repeat (3) @(negedge ph1);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_divzero", {31'd0, divzero}, 32'd0);
        chk("rst_unsupported", {31'd0, unsupported}, 32'd0);
        reset = 1'b0;
        @(negedge ph1);

        wr_hi = 1'b1;
        wdata = 32'h0000_1234;
        @(negedge ph1);
        wr_hi = 1'b0;
        chk("mthi", hi, 32'h0000_1234);
        wr_lo = 1'b1;
        wdata = 32'h0000_5678;
        @(negedge ph1);
        wr_lo = 1'b0;
        chk("mtlo", lo, 32'h0000_5678);
        chk("mtlo_keeps_hi", hi, 32'h0000_1234);

        // mthi issued together with start must be discarded.
        wr_hi = 1'b1;
        wdata = 32'h0000_0BAD;
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 35);
        chk("mthi_with_start", hi, 32'h0000_1234);
        wait_done(34, "multu_max");

        launch(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 35);
        wait_done(34, "mult_neg");
        launch(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, 35);
        wait_done(34, "mult_minmin");

        div_case(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg");
        div_case(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "divu_100_7");
        div_case(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div_wrap");
        div_case(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, "divu_zero");

        // Reset in the middle of RUN aborts the operation and clears HI/LO.
        launch(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 35);
        repeat (11) @(negedge ph1);
        reset = 1'b1;
        @(negedge ph1);
        reset = 1'b0;
        void'(sb.pop_back());
        m_hi = 32'd0;
        m_lo = 32'd0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);

        // A start and an mtlo while busy are both ignored.
        launch(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b0, 35);
        repeat (4) @(negedge ph1);
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd7;
        b     = 32'd7;
        wr_lo = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(negedge ph1);
        start = 1'b0;
        wr_lo = 1'b0;
        chk("mtlo_busy", lo, 32'd0);
        wait_done(29, "multu_ignored_start");

        launch(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, 35);
        wait_done(34, "back_to_back");

        repeat (40) @(negedge ph1);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
